// File: rtl/wb_slave_bridge.sv
// Wishbone classic slave bridging one WB master to a single peripheral
// through a req/done handshake, with address-window decode, byte enables,
// bus-error response, response timeout and abort on CYC_I drop.
module wb_slave_bridge #(
    parameter int unsigned            ADDR_WIDTH     = 32,
    parameter int unsigned            DATA_WIDTH     = 32,
    parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR      = '0,
    parameter logic [ADDR_WIDTH-1:0]  ADDR_MASK      = '0,
    parameter int unsigned            TIMEOUT_CYCLES = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      CYC_I,
    input  logic                      STB_I,
    input  logic                      WE_I,
    input  logic [ADDR_WIDTH-1:0]     ADR_I,
    input  logic [DATA_WIDTH-1:0]     DAT_I,
    input  logic [DATA_WIDTH/8-1:0]   SEL_I,
    output logic [DATA_WIDTH-1:0]     DAT_O,
    output logic                      ACK_O,
    output logic                      ERR_O,
    output logic                      req_o,
    output logic                      we_o,
    output logic [ADDR_WIDTH-1:0]     addr_o,
    output logic [DATA_WIDTH-1:0]     wdata_o,
    output logic [DATA_WIDTH/8-1:0]   be_o,
    input  logic [DATA_WIDTH-1:0]     rdata_i,
    input  logic                      done_i,
    input  logic                      err_i,
    output logic                      timeout_o
);

    localparam int unsigned SEL_WIDTH = DATA_WIDTH / 8;
    // A zero-width counter is illegal, so keep at least one bit when disabled
    localparam int unsigned CNT_W     = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam bit          TO_EN     = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_RESP
    } state_t;

    state_t                 state, state_nxt;
    logic [CNT_W-1:0]       cnt, cnt_nxt;
    logic [DATA_WIDTH-1:0]  dat_nxt;
    logic                   ack_nxt, err_nxt, req_nxt, we_nxt, to_nxt;
    logic [ADDR_WIDTH-1:0]  addr_nxt;
    logic [DATA_WIDTH-1:0]  wdata_nxt;
    logic [SEL_WIDTH-1:0]   be_nxt;
    logic                   hit_c;
    logic                   expired_c;

    assign hit_c     = ((ADR_I & ADDR_MASK) == BASE_ADDR);
    assign expired_c = TO_EN && (cnt == CNT_LAST);

    // State, counter and all registered outputs
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            DAT_O     <= '0;
            ACK_O     <= 1'b0;
            ERR_O     <= 1'b0;
            req_o     <= 1'b0;
            we_o      <= 1'b0;
            addr_o    <= '0;
            wdata_o   <= '0;
            be_o      <= '0;
            timeout_o <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            DAT_O     <= dat_nxt;
            ACK_O     <= ack_nxt;
            ERR_O     <= err_nxt;
            req_o     <= req_nxt;
            we_o      <= we_nxt;
            addr_o    <= addr_nxt;
            wdata_o   <= wdata_nxt;
            be_o      <= be_nxt;
            timeout_o <= to_nxt;
        end
    end

    // Next-state and next-output decode; pulses default low, payload holds
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        dat_nxt   = DAT_O;
        ack_nxt   = 1'b0;
        err_nxt   = 1'b0;
        to_nxt    = 1'b0;
        req_nxt   = req_o;
        we_nxt    = we_o;
        addr_nxt  = addr_o;
        wdata_nxt = wdata_o;
        be_nxt    = be_o;

        case (state)
            ST_IDLE: begin
                if (CYC_I && STB_I) begin
                    if (hit_c) begin
                        addr_nxt  = ADR_I;
                        wdata_nxt = DAT_I;
                        be_nxt    = SEL_I;
                        we_nxt    = WE_I;
                        req_nxt   = 1'b1;
                        cnt_nxt   = '0;
                        state_nxt = ST_REQ;
                    end else begin
                        err_nxt   = 1'b1;
                        state_nxt = ST_RESP;
                    end
                end
            end
            ST_REQ: begin
                if (!CYC_I) begin
                    // Master abandoned the cycle: no response, done_i ignored
                    req_nxt   = 1'b0;
                    state_nxt = ST_IDLE;
                end else if (done_i) begin
                    req_nxt   = 1'b0;
                    state_nxt = ST_RESP;
                    if (err_i) begin
                        err_nxt = 1'b1;
                    end else begin
                        ack_nxt = 1'b1;
                        if (!we_o) begin
                            dat_nxt = rdata_i;
                        end
                    end
                end else if (expired_c) begin
                    req_nxt   = 1'b0;
                    err_nxt   = 1'b1;
                    to_nxt    = 1'b1;
                    state_nxt = ST_RESP;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            ST_RESP: begin
                // Strobe is not sampled here so the acked transfer is not re-accepted
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_wb_slave_bridge.sv
// Self-checking bench for wb_slave_bridge: a vector table of single
// transfers plus directed sequences for abort, back-to-back and reset.
module tb_wb_slave_bridge;

    localparam int unsigned AW    = 32;
    localparam int unsigned DW    = 32;
    localparam int unsigned SW    = DW / 8;
    localparam int unsigned NEVER = 255;
    localparam int unsigned NVEC  = 9;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          CYC_I = 1'b0, STB_I = 1'b0, WE_I = 1'b0;
    logic [AW-1:0] ADR_I = '0;
    logic [DW-1:0] DAT_I = '0;
    logic [SW-1:0] SEL_I = '0;
    logic [DW-1:0] DAT_O;
    logic          ACK_O, ERR_O, req_o, we_o, timeout_o;
    logic [AW-1:0] addr_o;
    logic [DW-1:0] wdata_o;
    logic [SW-1:0] be_o;
    logic [DW-1:0] rdata_i = '0;
    logic          done_i = 1'b0, err_i = 1'b0;

    always #5 clk = ~clk;

    wb_slave_bridge #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .BASE_ADDR     (32'h0000_1000),
        .ADDR_MASK     (32'h0000_F000),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .CYC_I    (CYC_I),
        .STB_I    (STB_I),
        .WE_I     (WE_I),
        .ADR_I    (ADR_I),
        .DAT_I    (DAT_I),
        .SEL_I    (SEL_I),
        .DAT_O    (DAT_O),
        .ACK_O    (ACK_O),
        .ERR_O    (ERR_O),
        .req_o    (req_o),
        .we_o     (we_o),
        .addr_o   (addr_o),
        .wdata_o  (wdata_o),
        .be_o     (be_o),
        .rdata_i  (rdata_i),
        .done_i   (done_i),
        .err_i    (err_i),
        .timeout_o(timeout_o)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic          we;
        logic [AW-1:0] adr;
        logic [DW-1:0] dat;
        logic [SW-1:0] sel;
        int unsigned   dly;      // done_i in req cycle dly+1; NEVER = no done
        logic [DW-1:0] rdata;
        logic          perr;
        int unsigned   exp_req;  // cycles req_o high
        int unsigned   exp_ack;
        int unsigned   exp_err;
        int unsigned   exp_to;
        int unsigned   exp_cyc;  // edge index after strobe at which ACK/ERR is seen
        logic [DW-1:0] exp_dat;
    } vec_t;

    vec_t vecs [NVEC];

    // One transfer: drive strobe, play the peripheral, count what comes back
    task automatic run_txn(input vec_t v, input int idx);
        int unsigned reqc = 0, ackc = 0, errc = 0, toc = 0, resp_cyc = 0;
        int unsigned cyc = 0, post = 0, unstable = 0, both = 0;
        @(negedge clk);
        CYC_I = 1'b1; STB_I = 1'b1; WE_I = v.we;
        ADR_I = v.adr; DAT_I = v.dat; SEL_I = v.sel;
        while (cyc < 40 && post < 3) begin
            @(posedge clk); #1;
            cyc++;
            done_i  = 1'b0;
            err_i   = 1'b0;
            rdata_i = $urandom;
            if (req_o) begin
                if (reqc == 0) begin
                    check($sformatf("v%0d_addr", idx),  addr_o,  v.adr);
                    check($sformatf("v%0d_wdata", idx), wdata_o, v.dat);
                    check($sformatf("v%0d_be", idx),    be_o,    v.sel);
                    check($sformatf("v%0d_we", idx),    we_o,    v.we);
                end else if (addr_o !== v.adr || wdata_o !== v.dat ||
                             be_o !== v.sel || we_o !== v.we) begin
                    unstable++;
                end
                reqc++;
                if (v.dly != NEVER && reqc == v.dly + 1) begin
                    done_i  = 1'b1;
                    err_i   = v.perr;
                    rdata_i = v.rdata;
                end
            end
            if (ACK_O && ERR_O) both++;
            if (ACK_O)     ackc++;
            if (ERR_O)     errc++;
            if (timeout_o) toc++;
            if ((ACK_O || ERR_O) && resp_cyc == 0) begin
                resp_cyc = cyc;
                CYC_I = 1'b0;
                STB_I = 1'b0;
            end
            if (resp_cyc != 0) post++;
        end
        CYC_I = 1'b0; STB_I = 1'b0; done_i = 1'b0; err_i = 1'b0;
        check($sformatf("v%0d_req_cycles", idx), reqc, v.exp_req);
        check($sformatf("v%0d_ack_count", idx),  ackc, v.exp_ack);
        check($sformatf("v%0d_err_count", idx),  errc, v.exp_err);
        check($sformatf("v%0d_to_count", idx),   toc,  v.exp_to);
        check($sformatf("v%0d_resp_cycle", idx), resp_cyc, v.exp_cyc);
        check($sformatf("v%0d_dat_o", idx),      DAT_O, v.exp_dat);
        check($sformatf("v%0d_payload_stable", idx), unstable, 0);
        check($sformatf("v%0d_ack_err_both", idx),   both, 0);
    endtask

    initial begin
        int unsigned reqc, ackc, errc, ack1, ack2;
        vec_t fin;

        //          we    adr            dat            sel     dly    rdata          perr req ack err to cyc dat
        vecs[0] = '{1'b0, 32'h0000_1010, 32'h0,         4'hF,   0,     32'hDEAD_BEEF, 1'b0, 1, 1, 0, 0, 2, 32'hDEAD_BEEF};
        vecs[1] = '{1'b1, 32'h0000_1020, 32'hA5A5_A5A5, 4'b0011, 3,    32'h7777_7777, 1'b0, 4, 1, 0, 0, 5, 32'hDEAD_BEEF};
        vecs[2] = '{1'b0, 32'h0000_2004, 32'h0,         4'hF,   NEVER, 32'h0,         1'b0, 0, 0, 1, 0, 1, 32'hDEAD_BEEF};
        vecs[3] = '{1'b0, 32'h0000_1030, 32'h0,         4'hF,   NEVER, 32'h0,         1'b0, 4, 0, 1, 1, 5, 32'hDEAD_BEEF};
        vecs[4] = '{1'b0, 32'h0000_1040, 32'h0,         4'hF,   1,     32'h1234_5678, 1'b1, 2, 0, 1, 0, 3, 32'hDEAD_BEEF};
        vecs[5] = '{1'b0, 32'h0000_1FFC, 32'h0,         4'hF,   2,     32'hCAFE_F00D, 1'b0, 3, 1, 0, 0, 4, 32'hCAFE_F00D};
        vecs[6] = '{1'b0, 32'h0000_1004, 32'h0,         4'b0100, 3,    32'h0BAD_F00D, 1'b0, 4, 1, 0, 0, 5, 32'h0BAD_F00D};
        vecs[7] = '{1'b1, 32'h0000_3000, 32'hFFFF_0000, 4'hF,   NEVER, 32'h0,         1'b0, 0, 0, 1, 0, 1, 32'h0BAD_F00D};
        vecs[8] = '{1'b1, 32'h0000_1008, 32'h1122_3344, 4'b1000, 0,    32'h9999_9999, 1'b1, 1, 0, 1, 0, 2, 32'h0BAD_F00D};

        // Power-on reset: everything low while rst is high
        #1 rst = 1'b1;
        #2;
        check("rst_req",   req_o, 0);
        check("rst_ack",   ACK_O, 0);
        check("rst_err",   ERR_O, 0);
        check("rst_to",    timeout_o, 0);
        check("rst_dat",   DAT_O, 0);
        check("rst_addr",  addr_o, 0);
        check("rst_wdata", wdata_o, 0);
        check("rst_be",    be_o, 0);
        check("rst_we",    we_o, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < int'(NVEC); i++) begin
            run_txn(vecs[i], i);
        end

        // Abort: drop CYC_I in the second REQ cycle with a simultaneous done_i
        @(negedge clk);
        CYC_I = 1'b1; STB_I = 1'b1; WE_I = 1'b0; ADR_I = 32'h0000_1060; SEL_I = 4'hF;
        @(posedge clk); #1;
        check("abort_req_up", req_o, 1);
        @(posedge clk); #1;
        check("abort_req_still_up", req_o, 1);
        CYC_I = 1'b0; STB_I = 1'b0; done_i = 1'b1; err_i = 1'b0; rdata_i = 32'h5555_5555;
        @(posedge clk); #1;
        done_i = 1'b0;
        check("abort_req_fall", req_o, 0);
        ackc = 0; errc = 0; reqc = 0;
        for (int c = 0; c < 4; c++) begin
            if (ACK_O) ackc++;
            if (ERR_O) errc++;
            if (req_o) reqc++;
            @(posedge clk); #1;
        end
        check("abort_no_ack", ackc, 0);
        check("abort_no_err", errc, 0);
        check("abort_no_req", reqc, 0);
        check("abort_dat_kept", DAT_O, 32'h0BAD_F00D);

        // Back-to-back reads with STB_I held through the first ACK
        @(negedge clk);
        CYC_I = 1'b1; STB_I = 1'b1; WE_I = 1'b0; ADR_I = 32'h0000_1070; SEL_I = 4'hF;
        reqc = 0; ackc = 0; errc = 0; ack1 = 0; ack2 = 0;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
            done_i = 1'b0;
            if (c == 3) check("b2b_no_accept_in_resp", req_o, 0);
            if (req_o) begin
                reqc++;
                done_i  = 1'b1;
                rdata_i = (reqc == 1) ? 32'h1111_0001 : 32'h2222_0002;
            end
            if (ERR_O) errc++;
            if (ACK_O) begin
                ackc++;
                if (ackc == 1) begin
                    ack1 = c;
                    check("b2b_dat_first", DAT_O, 32'h1111_0001);
                end
                if (ackc == 2) begin
                    ack2 = c;
                    CYC_I = 1'b0; STB_I = 1'b0;
                end
            end
        end
        CYC_I = 1'b0; STB_I = 1'b0; done_i = 1'b0;
        check("b2b_req_count", reqc, 2);
        check("b2b_ack_count", ackc, 2);
        check("b2b_err_count", errc, 0);
        check("b2b_ack1_cycle", ack1, 2);
        check("b2b_ack2_cycle", ack2, 5);
        check("b2b_dat_final", DAT_O, 32'h2222_0002);

        // Asynchronous reset in the middle of REQ
        @(negedge clk);
        CYC_I = 1'b1; STB_I = 1'b1; WE_I = 1'b1; ADR_I = 32'h0000_1080;
        DAT_I = 32'hABCD_0123; SEL_I = 4'b0110;
        @(posedge clk); #1;
        check("rstmid_req_up", req_o, 1);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check("rstmid_req_drop", req_o, 0);
        check("rstmid_ack", ACK_O, 0);
        check("rstmid_err", ERR_O, 0);
        check("rstmid_dat", DAT_O, 0);
        check("rstmid_addr", addr_o, 0);
        @(negedge clk);
        CYC_I = 1'b0; STB_I = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        ackc = 0; errc = 0; reqc = 0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            if (ACK_O) ackc++;
            if (ERR_O) errc++;
            if (req_o) reqc++;
        end
        check("rstmid_no_resp", ackc + errc, 0);
        check("rstmid_no_req", reqc, 0);

        // Normal read after reset recovery
        fin = '{1'b0, 32'h0000_10A0, 32'h0, 4'hF, 1, 32'h600D_CAFE, 1'b0, 2, 1, 0, 0, 3, 32'h600D_CAFE};
        run_txn(fin, 99);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global bound so a stuck handshake can never hang the run
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1);
    end

endmodule
